dma_bus_arbiter: RTL
====================

DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, width of the transfer counter.
REQ-002 SHALL have parameter WDT_LIMIT, default 64, maximum BG-asserted cycles when the watchdog is compiled in.
REQ-003 SHALL have port Clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_N  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port DMA_begin  in  1  external-device request to start a DMA transfer.
REQ-006 SHALL have port DMA_end  in  1  DMA controller completion pulse.
REQ-007 SHALL have port BR  in  1  DMA controller bus request.
REQ-008 SHALL have port cpu_d_busy  in  1  CPU data-memory access in flight.
REQ-009 SHALL have port cmd  out  1  registered one-cycle command pulse to the DMA controller.
REQ-010 SHALL have port BG  out  1  registered bus grant to the DMA controller.
REQ-011 SHALL have port cpu_stall  out  1  blocks new CPU data-memory accesses.
REQ-012 SHALL have port dma_done  out  1  registered one-cycle completion pulse to the CPU.
REQ-013 SHALL have port dma_count  out  WORD_SIZE  number of completed transfers.
REQ-014 SHALL have port dma_error  out  1  sticky watchdog error flag.

Function
REQ-015 SHALL implement the states IDLE, CMD, WAIT_BR, WAIT_IDLE, GRANT and RELEASE.
REQ-016 SHALL go IDLE->CMD when DMA_begin is sampled high, or when pending is set (pending then clears).
REQ-017 SHALL assert cmd=1 during CMD for exactly one cycle, then go to WAIT_BR.
REQ-018 SHALL go WAIT_BR->GRANT when BR=1 and cpu_d_busy=0, and WAIT_BR->WAIT_IDLE when BR=1 and cpu_d_busy=1; it SHALL stay in WAIT_BR while BR=0.
REQ-019 SHALL go WAIT_IDLE->GRANT on the first cycle with cpu_d_busy=0.
REQ-020 SHALL assert BG=1 only in GRANT, so BG rises exactly one edge after the qualifying condition.
REQ-021 SHALL assert cpu_stall=1 in WAIT_IDLE and GRANT, and 0 in all other states.
REQ-022 SHALL go GRANT->RELEASE when BR falls; BG=0 and cpu_stall=0 in RELEASE; RELEASE->IDLE after one cycle.
REQ-023 SHALL, when DMA_end is sampled high in any state, pulse dma_done one cycle later and increment dma_count, wrapping from 2^WORD_SIZE-1 to 0.
REQ-024 SHALL, when DMA_begin is sampled high outside IDLE, set the single pending flag; further requests while pending is set SHALL be dropped.
REQ-025 SHALL give DMA_begin and DMA_end on the same edge both effects independently.
REQ-026 SHALL NOT deassert BG while BR=1, except through the watchdog.

Reset
REQ-027 SHALL, while Reset_N=0, immediately force: state=IDLE, cmd=0, BG=0, cpu_stall=0, dma_done=0, dma_count=0, dma_error=0, pending=0.
REQ-028 SHALL handle reset during GRANT by dropping BG asynchronously, and SHALL drop any in-progress transfer without counting it.

Configuration
REQ-029 SHALL, with macro DMA_WATCHDOG_EN defined, count GRANT cycles. When the count reaches WDT_LIMIT, it SHALL force RELEASE (BG=0) and set dma_error=1 until reset; dma_count SHALL be unchanged.
REQ-030 SHALL, without DMA_WATCHDOG_EN, omit the counter, tie dma_error to 0, and allow GRANT to last indefinitely.

Verification
REQ-031 SHALL cover: release reset, pulse DMA_begin at edge 5, BR=1 at edge 8, cpu_d_busy=0 -> cmd=1 exactly at edge 6, BG=1 at edge 9, cpu_stall=1 at edge 9.
REQ-032 SHALL cover: BR=1 with cpu_d_busy=1 for 3 cycles -> BG stays 0 and cpu_stall=1 during the wait; BG=1 one edge after cpu_d_busy falls.
REQ-033 SHALL cover: BR falls in GRANT, then DMA_end pulse -> BG=0 next edge, dma_done one-cycle pulse, dma_count 0->1.
REQ-034 SHALL cover: DMA_begin pulsed during GRANT and again during RELEASE -> exactly one extra cmd pulse after IDLE; second request dropped.
REQ-035 SHALL cover: with DMA_WATCHDOG_EN and WDT_LIMIT=4, BR held high -> BG=0 after 4 GRANT cycles, dma_error=1 and sticky; without the macro, BG held for 100 cycles and dma_error=0.
REQ-036 SHALL cover: Reset_N pulsed low mid-GRANT with dma_count=3 -> BG=0 with no clock edge, dma_count=0, state IDLE.

Source files
------------

// File: rtl/dma_bus_arbiter.sv
// Bus arbiter between the CPU data port and a DMA controller: command handshake,
// grant sequencing, completion counting. Optional grant watchdog: DMA_WATCHDOG_EN.
module dma_bus_arbiter #(
   parameter int WORD_SIZE = 16,
   parameter int WDT_LIMIT = 64
) (
   input  logic                 Clk,
   input  logic                 Reset_N,
   input  logic                 DMA_begin,
   input  logic                 DMA_end,
   input  logic                 BR,
   input  logic                 cpu_d_busy,
   output logic                 cmd,
   output logic                 BG,
   output logic                 cpu_stall,
   output logic                 dma_done,
   output logic [WORD_SIZE-1:0] dma_count,
   output logic                 dma_error
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CMD       = 3'd1;
   localparam logic [2:0] WAIT_BR   = 3'd2;
   localparam logic [2:0] WAIT_IDLE = 3'd3;
   localparam logic [2:0] GRANT     = 3'd4;
   localparam logic [2:0] RELEASE   = 3'd5;

   if (WDT_LIMIT < 1) begin : g_bad_wdt_limit
      $error("dma_bus_arbiter: WDT_LIMIT must be at least 1");
   end

   logic [2:0]           state_q, state_d;
   logic                 pending_q, pending_d;
   logic                 cmd_q, cmd_d;
   logic                 bg_q, bg_d;
   logic                 stall_q, stall_d;
   logic                 done_q, done_d;
   logic [WORD_SIZE-1:0] count_q, count_d;

`ifdef DMA_WATCHDOG_EN
   localparam int WDT_W = $clog2(WDT_LIMIT + 1);
   logic [WDT_W-1:0] wdt_q, wdt_d;
   logic             error_q, error_d;
   logic             wdt_fire;
`endif

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         IDLE: begin
            if (DMA_begin || pending_q) begin
               state_d   = CMD;
               pending_d = 1'b0;
            end
         end
         CMD:       state_d = WAIT_BR;
         WAIT_BR: begin
            if (BR) state_d = cpu_d_busy ? WAIT_IDLE : GRANT;
         end
         WAIT_IDLE: begin
            if (!cpu_d_busy) state_d = GRANT;
         end
         GRANT: begin
            if (!BR) state_d = RELEASE;
         end
         RELEASE:   state_d = IDLE;
         default:   state_d = IDLE;
      endcase

      // Only one request is remembered while busy; a set flag simply stays set.
      if (state_q != IDLE && DMA_begin) pending_d = 1'b1;

`ifdef DMA_WATCHDOG_EN
      wdt_fire = (state_q == GRANT) && (wdt_q == WDT_W'(WDT_LIMIT - 1));
      wdt_d    = (state_q == GRANT) ? wdt_q + WDT_W'(1) : '0;
      error_d  = error_q;
      if (wdt_fire) begin
         state_d = RELEASE;
         error_d = 1'b1;
      end
`endif

      cmd_d   = (state_d == CMD);
      bg_d    = (state_d == GRANT);
      stall_d = (state_d == WAIT_IDLE) || (state_d == GRANT);
      done_d  = DMA_end;
      count_d = DMA_end ? count_q + WORD_SIZE'(1) : count_q;
   end

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         cmd_q     <= 1'b0;
         bg_q      <= 1'b0;
         stall_q   <= 1'b0;
         done_q    <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cmd_q     <= cmd_d;
         bg_q      <= bg_d;
         stall_q   <= stall_d;
         done_q    <= done_d;
         count_q   <= count_d;
      end
   end

`ifdef DMA_WATCHDOG_EN
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         wdt_q   <= '0;
         error_q <= 1'b0;
      end else begin
         wdt_q   <= wdt_d;
         error_q <= error_d;
      end
   end

   assign dma_error = error_q;
`else
   assign dma_error = 1'b0;
`endif

   assign cmd       = cmd_q;
   assign BG        = bg_q;
   assign cpu_stall = stall_q;
   assign dma_done  = done_q;
   assign dma_count = count_q;

endmodule
